// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave read-path transmit sequencer.
package i2c_slave_pkg;

    localparam int I2C_BYTE_W = 8;
    localparam logic [I2C_BYTE_W-1:0] I2C_UNDERRUN_BYTE = 8'hFF;
    localparam int I2C_BIT_CNT_W = $clog2(I2C_BYTE_W);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        ACK,
        WAIT_FALL
    } tx_state_e;

    // True when the counter points at the last (LSB) bit of a byte.
    function automatic logic is_last_bit(input logic [I2C_BIT_CNT_W-1:0] cnt);
        return cnt == I2C_BIT_CNT_W'(I2C_BYTE_W - 1);
    endfunction

endpackage

// File: rtl/i2c_slave_tx_ctrl_if.sv
// Bus-condition strobes, register-file handshake and SDA drive of the transmit sequencer.
interface i2c_slave_tx_ctrl_if;

    logic                                en;
    logic                                scl_fall;
    logic                                scl_rise;
    logic                                start_det;
    logic                                stop_det;
    logic                                sda_in;
    logic                                tx_start;
    logic [i2c_slave_pkg::I2C_BYTE_W-1:0] tx_data;
    logic                                tx_valid;
    logic                                tx_ready;
    logic                                sda_pull;
    logic                                busy;
    logic                                nack;
    logic                                underrun;

    modport slave (
        input  en, scl_fall, scl_rise, start_det, stop_det, sda_in,
        input  tx_start, tx_data, tx_valid,
        output tx_ready, sda_pull, busy, nack, underrun
    );

    modport master (
        output en, scl_fall, scl_rise, start_det, stop_det, sda_in,
        output tx_start, tx_data, tx_valid,
        input  tx_ready, sda_pull, busy, nack, underrun
    );

endinterface

// File: rtl/i2c_slave_tx_ctrl_piso.sv
// Parallel-in serial-out shift register, MSB first, synchronous clear.
module i2c_slave_tx_ctrl_piso #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    input  logic             load,
    input  logic [DEPTH-1:0] din,
    output logic             serial_out
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Load wins over shift; shifting in 1 keeps a stale tail looking like a released bus.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (en) begin
            sr_d = {sr_q[DEPTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign serial_out = sr_q[DEPTH-1];

endmodule

// File: rtl/i2c_slave_tx_ctrl.sv
// I2C slave read-path sequencer: fetches bytes, shifts them onto SDA, handles the master ACK slot.
module i2c_slave_tx_ctrl
    import i2c_slave_pkg::*;
#(
    parameter int DATA_W = I2C_BYTE_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    i2c_slave_tx_ctrl_if.slave   bus
);

    localparam int CNT_W = $clog2(DATA_W);

    tx_state_e          state_q;
    tx_state_e          state_d;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [CNT_W-1:0]   bit_cnt_d;
    logic               nack_q;
    logic               nack_d;
    logic               srst_q;

    logic               in_load;
    logic               piso_en;
    logic               piso_load;
    logic [DATA_W-1:0]  piso_din;
    logic               piso_out;

    // Asserts with rst_n, releases on the first clock edge after it, so the PISO clears synchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srst_q <= 1'b1;
        end else begin
            srst_q <= 1'b0;
        end
    end

    assign in_load   = (state_q == LOAD) && bus.en;
    assign piso_load = in_load;
    assign piso_din  = bus.tx_valid ? bus.tx_data : I2C_UNDERRUN_BYTE;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        nack_d    = 1'b0;
        piso_en   = 1'b0;

        if (!bus.en) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end else if (bus.stop_det || bus.start_det) begin
            // Bus condition aborts silently; a byte fetched this cycle is simply dropped.
            state_d   = IDLE;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.tx_start) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
                SHIFT: begin
                    if (bus.scl_fall) begin
                        if (is_last_bit(bit_cnt_q)) begin
                            state_d = ACK;
                        end else begin
                            piso_en   = 1'b1;
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ACK: begin
                    if (bus.scl_rise) begin
                        if (bus.sda_in) begin
                            nack_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_FALL;
                        end
                    end
                end
                WAIT_FALL: begin
                    if (bus.scl_fall) begin
                        state_d = LOAD;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            nack_q    <= nack_d;
        end
    end

    i2c_slave_tx_ctrl_piso #(
        .DEPTH (DATA_W)
    ) u_piso (
        .clk        (clk),
        .srst       (srst_q),
        .en         (piso_en),
        .load       (piso_load),
        .din        (piso_din),
        .serial_out (piso_out)
    );

    assign bus.tx_ready = in_load && bus.tx_valid;
    assign bus.underrun = in_load && !bus.tx_valid;
    assign bus.sda_pull = (state_q == SHIFT) && !piso_out;
    assign bus.busy     = (state_q != IDLE);
    assign bus.nack     = nack_q;

endmodule

// File: doc/i2c_slave_tx_ctrl.md
# i2c_slave_tx_ctrl

Transmit-side sequencer for the I2C slave read path. After address match with R/W=1, it pulls bytes from the register-file side over a valid/ready handshake and loads them into an 8-bit `PISO` shift register. It shifts them out MSB-first on SCL falling edges, releases SDA for the master's ACK slot, and continues or terminates on ACK/NACK. It sits between the slave's bus-condition detector (START/STOP, SCL edge strobes) and the open-drain SDA output stage.

## Interface
- `DATA_W`, 8, byte width; only 8 is supported.
- `clk`  in  1  global clock
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `en`  in  1  device enable; low forces IDLE
- `scl_fall`  in  1  one-`clk` strobe, SCL falling edge (pre-synchronised)
- `scl_rise`  in  1  one-`clk` strobe, SCL rising edge
- `start_det`  in  1  one-`clk` strobe, START or repeated START seen
- `stop_det`  in  1  one-`clk` strobe, STOP seen
- `sda_in`  in  1  synchronised SDA level
- `tx_start`  in  1  one-`clk` strobe; address ACK slot ended, read transfer begins
- `tx_data`  in  8  next byte to send
- `tx_valid`  in  1  `tx_data` valid
- `tx_ready`  out  1  byte consumed this cycle (`tx_valid && tx_ready`)
- `sda_pull`  out  1  1 = drive SDA low; 0 = release
- `busy`  out  1  state != IDLE
- `nack`  out  1  one-`clk` pulse: master NACKed, transfer ended
- `underrun`  out  1  one-`clk` pulse: byte needed while `tx_valid`=0

## Operation
- States:
  - IDLE: waits for `tx_start`.
  - LOAD: fetches a byte.
  - SHIFT: sends bits 7..0.
  - ACK: SDA released; waits for the master's response.
  - WAIT_FALL: ACK received; waits for the SCL falling edge.
- IDLE -> LOAD on `tx_start` (when `en`=1). `tx_start` outside IDLE is ignored.
- LOAD, exactly one cycle:
  - With `tx_valid`=1: `tx_ready`=1 combinationally, PISO `load`=1 with `tx_data`.
  - With `tx_valid`=0: load 8'hFF (bus released), pulse `underrun`, no handshake.
  - Either case: bit_cnt<=0, -> SHIFT.
- SHIFT:
  - On `scl_fall` with bit_cnt<7: PISO shift (`en`=1, `load`=0), bit_cnt++.
  - On `scl_fall` with bit_cnt==7: -> ACK.
- ACK, on `scl_rise`:
  - `sda_in`=0 -> WAIT_FALL.
  - `sda_in`=1 -> pulse `nack`, -> IDLE.
- WAIT_FALL -> LOAD on `scl_fall`.
- `sda_pull` = (state==SHIFT) && !piso_serial_out. It is 0 in every other state.
- bit_cnt is 3 bits and never wraps inside SHIFT.
- Priority per cycle, highest first: `rst_n`, then `en`=0, then `stop_det`/`start_det`, then `scl_rise`/`scl_fall`.
  - `stop_det` or `start_det` in any state -> IDLE next cycle with `sda_pull`=0. No `nack` pulse. A byte already handshaken is discarded.
  - `en`=0 -> IDLE; the PISO is held.
- Reset mid-transfer: all state cleared immediately, SDA released.

## Timing
- Reset values:
  - `sda_pull`=0, `tx_ready`=0, `busy`=0, `nack`=0, `underrun`=0.
  - state=IDLE, bit_cnt=0, PISO cleared.
- `tx_start` at cycle T: LOAD at T+1 (`tx_ready` high at T+1). Bit 7 drives `sda_pull` from T+2.
- SCL low must last at least 3 `clk` for bit 7 setup; this is a system requirement, not checked.
- `scl_fall` at cycle T in SHIFT: the next bit appears on `sda_pull` at T+1.
- 8th `scl_fall`: `sda_pull`=0 at T+1.
- `scl_rise` in ACK at T: `nack` pulses at T+1 and `busy`=0 at T+1.
- ACK then `scl_fall` at T: LOAD at T+1, next MSB at T+2.
- `tx_ready` is high only in LOAD and never for two consecutive cycles.
- `scl_rise` and `scl_fall` in the same cycle cannot occur; behaviour in that case is undefined.

## Structure
- `i2c_slave_pkg`:
  - typedef `tx_state_e` (IDLE, LOAD, SHIFT, ACK, WAIT_FALL)
  - `I2C_BYTE_W`=8
  - `I2C_UNDERRUN_BYTE`=8'hFF
- One sub-module: `PISO` with DEPTH=8. Its reset is driven from a synchronous reset derived from `rst_n`.
- The controller itself is a single always_ff FSM plus bit counter, with combinational outputs.

## Test plan
- Single byte ACK then NACK: `tx_start`, `tx_data`=8'hA5 valid.
  - `sda_pull` sequence over 8 SCL lows is 0,1,0,1,1,0,1,0 (inverse of the bits).
  - Master ACKs and the next byte 8'h3C is fetched.
  - Master NACKs after 8'h3C: `nack` pulse, `busy`=0.
- Underrun: `tx_valid`=0 in LOAD.
  - `underrun` pulses once and `tx_ready` stays 0.
  - `sda_pull`=0 for all 8 bits.
- STOP mid-byte: `stop_det` after bit 3 of 8'h00.
  - IDLE and `sda_pull`=0 next cycle.
  - No `nack`; a following `tx_start` restarts from bit 7.
- Repeated START during the ACK slot: IDLE, no `tx_ready`, no `nack`.
- Async reset asserted while `sda_pull`=1:
  - `sda_pull` goes to 0 without a clk edge.
  - All outputs take their reset values; after release the block is idle.
- `en`=0 during SHIFT: IDLE, SDA released. `tx_start` is ignored until `en`=1.
